// File: rtl/dmem_line_responder.sv
// Fixed-latency 256-bit line memory answering the data cache's refill/writeback port.
// One request in flight: latch it, count LATENCY cycles, commit or read, pulse ack_o.
module dmem_line_responder #(
   parameter int unsigned LATENCY = 10,
   parameter int unsigned DEPTH   = 512,
   parameter int unsigned IDX_W   = 9
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   input  logic         enable_i,
   input  logic         write_i,
   output logic         ack_o,
   output logic [255:0] data_o
);

   typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

   localparam logic [7:0] CntInit = 8'(LATENCY - 1);
   localparam bit         Direct  = (LATENCY == 1);

   state_e             state_q;
   logic [7:0]         cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic               wr_q;
   logic [255:0]       wdata_q;
   logic [255:0]       data_q;
   logic               ack_q;
   logic [255:0]       mem_q [DEPTH];

   logic               commit_en;
   logic               commit_wr;
   logic [IDX_W-1:0]   commit_idx;
   logic [255:0]       commit_data;

   logic               unused_addr;
   assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

   // With LATENCY=1 the commit happens on the accepting edge, so use the live request.
   always_comb begin
      commit_en   = 1'b0;
      commit_wr   = wr_q;
      commit_idx  = idx_q;
      commit_data = wdata_q;
      unique case (state_q)
         StIdle: begin
            commit_en   = Direct && enable_i;
            commit_wr   = write_i;
            commit_idx  = addr_i[IDX_W+4:5];
            commit_data = data_i;
         end
         StWait:  commit_en = (cnt_q == 8'd0);
         default: commit_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         ack_q   <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         ack_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (enable_i) begin
                  idx_q   <= addr_i[IDX_W+4:5];
                  wr_q    <= write_i;
                  wdata_q <= data_i;
                  cnt_q   <= CntInit;
                  if (Direct) begin
                     state_q <= StAck;
                     ack_q   <= 1'b1;
                  end else begin
                     state_q <= StWait;
                  end
               end
            end
            StWait: begin
               if (cnt_q == 8'd0) begin
                  state_q <= StAck;
                  ack_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            StAck:   state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
         if (commit_en && !commit_wr) begin
            data_q <= mem_q[commit_idx];
         end
      end
   end

   // Array is deliberately not reset; a reset edge suppresses any pending commit.
   always_ff @(posedge clk_i) begin
      if (rst_i && commit_en && commit_wr) begin
         mem_q[commit_idx] <= commit_data;
      end
   end

   assign ack_o  = ack_q;
   assign data_o = data_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Scoreboarded bench for dmem_line_responder: a LATENCY=10 instance driven through
// single and back-to-back transactions, plus a LATENCY=1 instance under held enable.
module tb_dmem_line_responder;

   localparam int unsigned Lat = 10;

   typedef struct {
      int unsigned cyc;
      logic [255:0] data;
      string tag;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n, en, wr, ack;
   logic [31:0]  addr;
   logic [255:0] wdata, rdata;

   logic         rst1_n, en1, wr1, ack1;
   logic [31:0]  addr1;
   logic [255:0] wdata1, rdata1;

   int unsigned  cyc = 0;
   int           n_vec = 0;
   int           n_bad = 0;
   exp_t         sb_q[$];
   logic [255:0] mdl [512];
   logic [255:0] mdl1 [4];
   logic [255:0] last_rd;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_line_responder #(.LATENCY(Lat), .DEPTH(512), .IDX_W(9)) u_dut (
      .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata),
      .enable_i(en), .write_i(wr), .ack_o(ack), .data_o(rdata)
   );

   dmem_line_responder #(.LATENCY(1), .DEPTH(512), .IDX_W(9)) u_dut1 (
      .clk_i(clk), .rst_i(rst1_n), .addr_i(addr1), .data_i(wdata1),
      .enable_i(en1), .write_i(wr1), .ack_o(ack1), .data_o(rdata1)
   );

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive a request that the DUT will accept on the next edge and queue its outcome.
   task automatic issue(input logic w, input logic [31:0] a, input logic [255:0] d,
                        input string tag);
      logic [8:0] idx;
      exp_t e;
      idx   = a[13:5];
      wr    = w;
      addr  = a;
      wdata = d;
      en    = 1'b1;
      if (w) mdl[idx] = d;
      else   last_rd = mdl[idx];
      e.cyc  = cyc + 1 + Lat;
      e.data = last_rd;
      e.tag  = tag;
      sb_q.push_back(e);
   endtask

   task automatic wait_ack(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack !== 1'b1 && n < 40);
      if (ack !== 1'b1) check_eq({tag, "_timeout"}, {255'd0, ack}, 256'd1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (ack === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_ack", {255'd0, ack}, 256'd0);
         end else begin
            e = sb_q.pop_front();
            check_eq({e.tag, "_cyc"}, 256'(cyc), 256'(e.cyc));
            check_eq({e.tag, "_data"}, rdata, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned a1;
      rst_n = 1'b0; en = 1'b1; wr = 1'b0; addr = 32'h0000_0060; wdata = '0;
      rst1_n = 1'b0; en1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
      last_rd = '0;
      for (int i = 0; i < 16; i++) begin
         mdl[i] = {8{$urandom()}};
         u_dut.mem_q[i] = mdl[i];
      end
      mdl[3] = {32{8'hA5}};
      u_dut.mem_q[3] = mdl[3];
      for (int i = 0; i < 4; i++) begin
         mdl1[i] = {8{$urandom()}};
         u_dut1.mem_q[i] = mdl1[i];
      end

      // Reset held with a request pending: nothing may happen.
      repeat (3) begin
         @(negedge clk);
         check_eq("rst_ack", {255'd0, ack}, 256'd0);
         check_eq("rst_data", rdata, 256'd0);
      end
      rst_n  = 1'b1;
      rst1_n = 1'b1;
      issue(1'b0, 32'h0000_0060, '0, "rd_lat");
      wait_ack("rd_lat");
      @(posedge clk); #1;
      en = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check_eq("rd_one_pulse", {255'd0, ack}, 256'd0);
      end
      check_eq("rd_hold", rdata, {32{8'hA5}});

      // Write then read-back; next request is sampled one cycle after ACK ends.
      @(negedge clk);
      issue(1'b1, 32'h0000_0400, {8{32'hDEADBEEF}}, "wr400");
      wait_ack("wr400");
      a1 = cyc;
      @(posedge clk); #1;
      issue(1'b0, 32'h0000_0400, '0, "rd400");
      wait_ack("rd400");
      check_eq("wr_rd_gap", 256'(cyc - a1), 256'(Lat + 2));
      check_eq("rd400_val", rdata, {8{32'hDEADBEEF}});

      // Writeback then fill of an aliasing address (same index, different tag).
      @(posedge clk); #1;
      issue(1'b1, 32'h0001_0020, {8{32'hC0FFEE11}}, "wb");
      wait_ack("wb");
      check_eq("wb_mem", u_dut.mem_q[1], {8{32'hC0FFEE11}});
      @(posedge clk); #1;
      issue(1'b0, 32'h0000_0020, '0, "fill");
      wait_ack("fill");

      // Write to index 7 aborted by reset on the 4th WAIT cycle.
      @(posedge clk); #1;
      wr = 1'b1; addr = 32'h0000_00E0; wdata = {8{32'hBAD0BAD0}}; en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0; en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_rd = '0;
      repeat (15) begin
         @(negedge clk);
         check_eq("abort_no_ack", {255'd0, ack}, 256'd0);
      end
      check_eq("abort_data", rdata, 256'd0);
      check_eq("abort_mem", u_dut.mem_q[7], mdl[7]);
      issue(1'b0, 32'h0000_00E0, '0, "rd7");
      wait_ack("rd7");
      @(posedge clk); #1;
      en = 1'b0;

      // LATENCY=1: held enable gives accept/ACK alternation, new line each ack.
      @(negedge clk);
      en1 = 1'b1; addr1 = 32'h0;
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         if (s % 2 == 0) begin
            check_eq("l1_ack", {255'd0, ack1}, 256'd1);
            check_eq("l1_data", rdata1, mdl1[s/2]);
            addr1 = 32'((s / 2 + 1) % 4) << 5;
         end else begin
            check_eq("l1_gap", {255'd0, ack1}, 256'd0);
         end
      end
      en1 = 1'b0;

      repeat (3) @(negedge clk);
      check_eq("sb_empty", 256'(sb_q.size()), 256'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
